// File: rtl/rr_arb_mux_pkg.sv
// rr_arb_mux shared definitions: sizing rule and grant helpers.
// Imported by the interface, the picker and the top level.
package arb_mux_pkg;

    localparam int MAX_CHANS = 64;

    // Index width for a channel count; never narrower than one bit.
    function automatic int ptr_w(input int chans);
        return (chans > 1) ? $clog2(chans) : 1;
    endfunction

    function automatic logic onehot_ok(input logic [MAX_CHANS-1:0] vec);
        return $countones(vec) == 1;
    endfunction

    // Pointer after a grant to k; an out-of-range k leaves it alone.
    function automatic int rr_next(input int ptr, input int k, input int chans);
        if (k < 0 || k >= chans)
            return ptr;
        return (k + 1) % chans;
    endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// rr_arb_mux bus: producer handshakes, force controls, output stage.
// master = producers/consumer side, slave = the mux.
interface rr_arb_mux_if #(
    parameter int CHANS = 16,
    parameter int WIDTH = 8
);
    import arb_mux_pkg::*;

    localparam int IW = ptr_w(CHANS);

    logic [CHANS-1:0]            in_valid;
    logic [CHANS-1:0][WIDTH-1:0] in_data;
    logic [CHANS-1:0]            in_ready;
    logic                        force_en;
    logic [CHANS-1:0]            force_sel;
    logic                        out_valid;
    logic [WIDTH-1:0]            out_data;
    logic [IW-1:0]               out_chan;
    logic                        out_ready;
    logic                        sel_err;

    modport master (
        output in_valid, in_data, force_en, force_sel, out_ready,
        input  in_ready, out_valid, out_data, out_chan, sel_err
    );

    modport slave (
        input  in_valid, in_data, force_en, force_sel, out_ready,
        output in_ready, out_valid, out_data, out_chan, sel_err
    );

endinterface

// File: rtl/rr_arb_mux_pick.sv
// Round-robin picker: rotate requests so ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
    parameter int CHANS = 16,
    parameter int IW    = 4
) (
    input  logic [CHANS-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [CHANS-1:0] gnt,
    output logic [IW-1:0]    gnt_idx,
    output logic             any
);

    logic [CHANS-1:0] rot;
    logic             hit;
    int               off;
    int               sum;

    // Double-width rotate then lowest-set-bit priority encode.
    always_comb begin
        rot = CHANS'({req, req} >> ptr);
        hit = 1'b0;
        off = 0;
        for (int i = 0; i < CHANS; i++) begin
            if (!hit && rot[i]) begin
                hit = 1'b1;
                off = i;
            end
        end
        sum = int'(ptr) + off;
        if (sum >= CHANS)
            sum = sum - CHANS;
        any     = hit;
        gnt_idx = IW'(sum);
        gnt     = '0;
        if (hit)
            gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel round-robin / forced-select mux with a
// registered output stage and a sticky bad-select flag.
module rr_arb_mux
    import arb_mux_pkg::*;
#(
    parameter int CHANS = 16,
    parameter int WIDTH = 8
) (
    input logic         clk,
    input logic         rst_n,
    rr_arb_mux_if.slave bus
);

    localparam int IW = ptr_w(CHANS);

    logic [IW-1:0]          ptr;
    logic                   q_valid;
    logic [WIDTH-1:0]       q_data;
    logic [IW-1:0]          q_chan;
    logic                   q_err;
    logic                   load;
    logic                   f_ok;
    logic [CHANS-1:0]       rr_gnt;
    logic [IW-1:0]          rr_idx;
    logic                   rr_any;
    logic [IW-1:0]          f_idx;
    logic [IW-1:0]          gidx;
    logic [CHANS-1:0]       gnt;
    logic                   take;
    logic [MAX_CHANS-1:0]   fsel_x;

    rr_pick #(
        .CHANS (CHANS),
        .IW    (IW)
    ) u_pick (
        .req     (bus.in_valid),
        .ptr     (ptr),
        .gnt     (rr_gnt),
        .gnt_idx (rr_idx),
        .any     (rr_any)
    );

    assign load   = !q_valid || bus.out_ready;
    assign fsel_x = MAX_CHANS'(bus.force_sel);
    assign f_ok   = onehot_ok(fsel_x);
    assign gidx   = bus.force_en ? f_idx : rr_idx;
    assign take   = |gnt;

    // Index of the forced channel (meaningful only when one-hot).
    always_comb begin
        f_idx = '0;
        for (int i = 0; i < CHANS; i++) begin
            if (bus.force_sel[i])
                f_idx = IW'(i);
        end
    end

    // Grant: forced channel or round-robin winner, only when loadable.
    always_comb begin
        gnt = '0;
        if (rst_n && load) begin
            if (bus.force_en) begin
                if (f_ok)
                    gnt = bus.force_sel & bus.in_valid;
            end else if (rr_any) begin
                gnt = rr_gnt;
            end
        end
    end

    // Output register, rr pointer and sticky select error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_valid <= 1'b0;
            q_data  <= '0;
            q_chan  <= '0;
            q_err   <= 1'b0;
            ptr     <= '0;
        end else begin
            if (bus.force_en && !f_ok)
                q_err <= 1'b1;
            if (load) begin
                q_valid <= take;
                if (take) begin
                    q_data <= bus.in_data[gidx];
                    q_chan <= gidx;
                    if (!bus.force_en)
                        ptr <= IW'(rr_next(int'(ptr), int'(gidx), CHANS));
                end
            end
        end
    end

    assign bus.in_ready  = gnt;
    assign bus.out_valid = q_valid;
    assign bus.out_data  = q_data;
    assign bus.out_chan  = q_chan;
    assign bus.sel_err   = q_err;

endmodule

// File: tb/tb_rr_arb_mux.sv
// rr_arb_mux bench: directed scenarios plus random traffic against
// a queue-based reference model and a decoupled output monitor.
module tb_rr_arb_mux;

    localparam int CHANS = 16;
    localparam int WIDTH = 8;

    typedef struct {
        int               chan;
        logic [WIDTH-1:0] data;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    rr_arb_mux_if #(.CHANS(CHANS), .WIDTH(WIDTH)) bus ();

    rr_arb_mux #(
        .CHANS (CHANS),
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    errs   = 0;
    int    checks = 0;
    item_t q[$];
    int    mptr   = 0;
    bit    mvalid = 1'b0;
    bit    merr   = 1'b0;
    bit    armed  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Channel the arbitration rules say wins now, or -1.
    function automatic int model_pick();
        if (bus.force_en) begin
            if ($countones(bus.force_sel) != 1)
                return -1;
            for (int c = 0; c < CHANS; c++)
                if (bus.force_sel[c])
                    return bus.in_valid[c] ? c : -1;
            return -1;
        end
        for (int s = 0; s < CHANS; s++) begin
            int c;
            c = (mptr + s) % CHANS;
            if (bus.in_valid[c])
                return c;
        end
        return -1;
    endfunction

    // Reference model: per-cycle expectations and scoreboard pushes.
    always @(negedge clk) begin : model
        logic [CHANS-1:0] exp_rdy;
        int               k;
        bit               load;
        if (!rst_n)
            armed = 1'b1;
        if (armed) begin
            chk("out_valid", 64'(bus.out_valid), 64'(mvalid));
            chk("sel_err", 64'(bus.sel_err), 64'(merr));
            exp_rdy = '0;
            k = -1;
            load = !mvalid || bus.out_ready;
            if (rst_n && load)
                k = model_pick();
            if (k >= 0)
                exp_rdy[k] = 1'b1;
            chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
            if (!rst_n) begin
                mvalid = 1'b0;
                mptr   = 0;
                merr   = 1'b0;
                q.delete();
            end else begin
                if (bus.force_en && $countones(bus.force_sel) != 1)
                    merr = 1'b1;
                if (load) begin
                    if (k >= 0) begin
                        q.push_back('{k, bus.in_data[k]});
                        mvalid = 1'b1;
                        if (!bus.force_en)
                            mptr = (k + 1) % CHANS;
                    end else begin
                        mvalid = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: compare each accepted output against the scoreboard.
    always @(negedge clk) begin : monitor
        item_t it;
        if (armed && rst_n && bus.out_valid === 1'b1 && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errs++;
                $display("FAIL xfer_unexpected actual=chan %0d required=none",
                         bus.out_chan);
            end else begin
                it = q.pop_front();
                chk("xfer_chan", 64'(bus.out_chan), 64'(it.chan));
                chk("xfer_data", 64'(bus.out_data), 64'(it.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int c = 0; c < CHANS; c++)
            bus.in_data[c] = WIDTH'($urandom);
    endtask

    initial begin
        bus.in_valid  = '1;
        bus.out_ready = 1'b0;
        bus.force_en  = 1'b0;
        bus.force_sel = '0;
        rand_data();

        // Reset held for two edges with every channel requesting.
        tick();
        tick();
        @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_sel_err", 64'(bus.sel_err), 64'd0);
        chk("rst_out_chan", 64'(bus.out_chan), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);

        // Fairness: all requesting, consumer always ready.
        tick();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            rand_data();
            @(negedge clk);
            chk("fair_chan", 64'(bus.out_chan), 64'(i % CHANS));
            chk("fair_valid", 64'(bus.out_valid), 64'd1);
        end

        // Sparse wrap with ptr=1: 15, 0, 15.
        tick();
        bus.in_valid = 16'h8001;
        tick();
        @(negedge clk);
        chk("wrap_a", 64'(bus.out_chan), 64'd15);
        tick();
        @(negedge clk);
        chk("wrap_b", 64'(bus.out_chan), 64'd0);
        tick();
        bus.in_valid = 16'h0008;
        bus.in_data[3] = 8'hA5;
        @(negedge clk);
        chk("wrap_c", 64'(bus.out_chan), 64'd15);

        // Backpressure: A5 must hold while the consumer stalls.
        tick();
        bus.out_ready = 1'b0;
        bus.in_data[3] = 8'h5A;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("bp_data", 64'(bus.out_data), 64'hA5);
            chk("bp_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_ready", 64'(bus.in_ready), 64'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        bus.in_valid = '0;
        tick();
        @(negedge clk);
        chk("bp_drop", 64'(bus.out_valid), 64'd0);

        // Forced mode: move ptr to 1 first, force channel 4.
        tick();
        bus.in_valid = 16'h0001;
        tick();
        bus.force_en = 1'b1;
        bus.force_sel = 16'h0010;
        bus.in_valid = '1;
        for (int j = 0; j < 4; j++) begin
            tick();
            rand_data();
            @(negedge clk);
            chk("force_chan", 64'(bus.out_chan), 64'd4);
        end
        tick();
        bus.force_en = 1'b0;
        tick();
        bus.force_en = 1'b1;
        bus.force_sel = 16'h0011;
        @(negedge clk);
        chk("force_exit_ptr", 64'(bus.out_chan), 64'd1);
        chk("bad_no_ready", 64'(bus.in_ready), 64'd0);

        // Bad select: sticky until reset.
        tick();
        bus.force_en = 1'b0;
        @(negedge clk);
        chk("bad_err", 64'(bus.sel_err), 64'd1);
        chk("bad_drain", 64'(bus.out_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("bad_sticky", 64'(bus.sel_err), 64'd1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("bad_clear", 64'(bus.sel_err), 64'd0);

        // Random traffic, occasional force and reset.
        for (int n = 0; n < 600; n++) begin
            tick();
            rst_n = ($urandom_range(0, 63) != 0);
            bus.in_valid = CHANS'($urandom) & CHANS'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.force_en = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 4) != 0)
                bus.force_sel = CHANS'(1) << $urandom_range(0, CHANS - 1);
            else
                bus.force_sel = CHANS'($urandom);
            rand_data();
        end

        // Drain: every scoreboard entry must have left the DUT.
        tick();
        rst_n = 1'b1;
        bus.in_valid = '0;
        bus.force_en = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("drain_empty", 64'(q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
